spike_encoder: RTL

Temporal (race-logic) encoder that drives the spike side of the kwta column: converts a vector of per-input spike times into pulse-coded spikes inside one gamma cycle. Accepts one value vector per gamma cycle through a valid/ready handshake, double-buffered so frames run back-to-back. Emits a gamma-cycle reset for the downstream kwta/less_than_eq/sr_latch cells between frames. Sits between the sample source and the kwta column.

---
 rtl/spike_encoder_pkg.sv | 25 ++
 rtl/spike_slot.sv | 52 +++++
 rtl/spike_encoder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/spike_encoder_pkg.sv
// Shared types and sizing helpers for the race-logic spike encoder.
// The top and the per-lane slot both import this package.
package spike_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RESET = 2'd2
    } state_e;

    localparam int DEFAULT_GAMMA_CYCLE_WIDTH = 16;
    localparam int DEFAULT_PULSE_WIDTH       = 8;
    localparam int FRAME_TICKS = DEFAULT_GAMMA_CYCLE_WIDTH + DEFAULT_PULSE_WIDTH;
    localparam int TICK_WIDTH  = $clog2(FRAME_TICKS) + 1;

    // Frame sizing for non-default parameterisations of the encoder.
    function automatic int frame_ticks_for(input int gamma_width, input int pulse_width);
        return gamma_width + pulse_width;
    endfunction

    function automatic int tick_width_for(input int gamma_width, input int pulse_width);
        return $clog2(gamma_width + pulse_width) + 1;
    endfunction

endpackage

// File: rtl/spike_slot.sv
// One spike lane: registers a pulse of PULSE_WIDTH clocks that starts at the
// lane's spike time, judged against the tick the frame will be on next cycle.
module spike_slot
    import spike_encoder_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = DEFAULT_GAMMA_CYCLE_WIDTH,
    parameter int PULSE_WIDTH       = DEFAULT_PULSE_WIDTH,
    parameter int VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH),
    parameter int TICK_W            = TICK_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TICK_W-1:0]      tick_next,
    input  logic [VALUE_WIDTH-1:0] spike_time,
    input  logic                   enable,
    input  logic                   run_next,
    output logic                   spike
);

    // One spare bit so time + PULSE_WIDTH never wraps.
    localparam int CW = TICK_W + 1;
    localparam logic [VALUE_WIDTH:0] GAMMA_LIM = (VALUE_WIDTH + 1)'(GAMMA_CYCLE_WIDTH);

    logic               spike_q;
    logic               spike_d;
    logic [VALUE_WIDTH:0] time_ext;
    logic [CW-1:0]      tick_c;
    logic [CW-1:0]      start_c;
    logic [CW-1:0]      end_c;
    logic               in_range;

    always_comb begin
        time_ext = {1'b0, spike_time};
        tick_c   = CW'(tick_next);
        start_c  = CW'(time_ext);
        end_c    = start_c + CW'(PULSE_WIDTH);
        in_range = (time_ext < GAMMA_LIM);
        spike_d  = run_next && enable && in_range &&
                   (tick_c >= start_c) && (tick_c < end_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike_d;
        end
    end

    assign spike = spike_q;

endmodule

// File: rtl/spike_encoder.sv
// Race-logic encoder: double-buffered value vectors become per-lane pulses
// inside one gamma cycle, followed by a one-clock downstream reset.
module spike_encoder
    import spike_encoder_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = DEFAULT_GAMMA_CYCLE_WIDTH,
    parameter int PULSE_WIDTH       = DEFAULT_PULSE_WIDTH,
    parameter int NUM_INPUTS        = 16,
    parameter int VALUE_WIDTH       = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_INPUTS*VALUE_WIDTH-1:0] in_times,
    input  logic [NUM_INPUTS-1:0]             in_enable,
    output logic [NUM_INPUTS-1:0]             output_spikes,
    output logic                              gamma_start,
    output logic                              gamma_rst,
    output logic                              busy
);

    localparam int FRAME_LEN = frame_ticks_for(GAMMA_CYCLE_WIDTH, PULSE_WIDTH);
    localparam int TICK_W    = tick_width_for(GAMMA_CYCLE_WIDTH, PULSE_WIDTH);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(FRAME_LEN - 1);

    state_e                            state_q, state_d;
    logic [TICK_W-1:0]                 tick_q, tick_d;
    logic                              pending_full_q, pending_full_d;
    logic [NUM_INPUTS*VALUE_WIDTH-1:0] pending_times_q, pending_times_d;
    logic [NUM_INPUTS-1:0]             pending_enable_q, pending_enable_d;
    logic [NUM_INPUTS*VALUE_WIDTH-1:0] active_times_q, active_times_d;
    logic [NUM_INPUTS-1:0]             active_enable_q, active_enable_d;
    logic                              transfer;
    logic                              load;
    logic                              run_next;

    always_comb begin
        state_d          = state_q;
        tick_d           = tick_q;
        pending_full_d   = pending_full_q;
        pending_times_d  = pending_times_q;
        pending_enable_d = pending_enable_q;
        active_times_d   = active_times_q;
        active_enable_d  = active_enable_q;
        load             = 1'b0;
        transfer         = in_valid && !pending_full_q;

        case (state_q)
            IDLE: begin
                if (pending_full_q) begin
                    load    = 1'b1;
                    state_d = RUN;
                    tick_d  = '0;
                end
            end
            RUN: begin
                if (tick_q == LAST_TICK) begin
                    state_d = RESET;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            RESET: begin
                tick_d = '0;
                if (pending_full_q) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = '0;
            end
        endcase

        // Load and capture are exclusive: capture needs the buffer empty.
        if (load) begin
            active_times_d  = pending_times_q;
            active_enable_d = pending_enable_q;
            pending_full_d  = 1'b0;
        end
        if (transfer) begin
            pending_times_d  = in_times;
            pending_enable_d = in_enable;
            pending_full_d   = 1'b1;
        end

        run_next = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            tick_q           <= '0;
            pending_full_q   <= 1'b0;
            pending_times_q  <= '0;
            pending_enable_q <= '0;
            active_times_q   <= '0;
            active_enable_q  <= '0;
        end else begin
            state_q          <= state_d;
            tick_q           <= tick_d;
            pending_full_q   <= pending_full_d;
            pending_times_q  <= pending_times_d;
            pending_enable_q <= pending_enable_d;
            active_times_q   <= active_times_d;
            active_enable_q  <= active_enable_d;
        end
    end

    // Lanes see the next-cycle tick and vector so each pulse is a clean flop output.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        spike_slot #(
            .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
            .PULSE_WIDTH      (PULSE_WIDTH),
            .VALUE_WIDTH      (VALUE_WIDTH),
            .TICK_W           (TICK_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .tick_next (tick_d),
            .spike_time(active_times_d[i*VALUE_WIDTH +: VALUE_WIDTH]),
            .enable    (active_enable_d[i]),
            .run_next  (run_next),
            .spike     (output_spikes[i])
        );
    end

    assign in_ready    = !pending_full_q;
    assign busy        = (state_q != IDLE);
    assign gamma_rst   = (state_q != RUN);
    assign gamma_start = (state_q == RUN) && (tick_q == '0);

endmodule
